// File: rtl/ex_flags_stage.sv
// Execute-to-writeback stage: registers the ALU result, owns the architectural
// flag register, resolves BRFL branches and squashes wrong-path entries.
module ex_flags_stage #(
    parameter int DATA_WIDTH   = 32,
    parameter int SQUASH_COUNT = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [2:0]            alu_flags,
    input  logic [5:0]            func,
    input  logic [4:0]            rd,
    input  logic [2:0]            brfl_mask,
    input  logic [DATA_WIDTH-1:0] brfl_target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [4:0]            out_rd,
    output logic                  out_we,
    output logic                  out_illegal,
    output logic                  branch_taken,
    output logic [DATA_WIDTH-1:0] branch_target,
    output logic [2:0]            flags
);

    typedef enum logic [1:0] {
        CLS_FLAG_SET,
        CLS_WRITE,
        CLS_BRANCH,
        CLS_ILLEGAL
    } func_class_t;

    localparam logic [1:0] SQUASH_RELOAD = 2'(SQUASH_COUNT);

    func_class_t func_class;
    logic [1:0]  squash_cnt;
    logic        accept;
    logic        squashing;
    logic        live;
    logic        taken;

    always_comb begin
        // NOTE: default assigned first so no path through the case infers a latch.
        func_class = CLS_ILLEGAL;
        case (func)
            6'b100000, 6'b100010, 6'b011000, 6'b011010: func_class = CLS_FLAG_SET;
            6'b100100, 6'b100101, 6'b100111:            func_class = CLS_WRITE;
            6'b111111:                                  func_class = CLS_BRANCH;
            default:                                    func_class = CLS_ILLEGAL;
        endcase
    end

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign squashing = squash_cnt != 2'd0;
    assign live      = accept && !squashing;
    // Uses the flag register as it stands before this edge, so a flag-setter
    // accepted one cycle earlier is already visible here.
    assign taken     = (func_class == CLS_BRANCH) && |(flags & brfl_mask);

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_rd        <= '0;
            out_we        <= 1'b0;
            out_illegal   <= 1'b0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
            flags         <= 3'b000;
            squash_cnt    <= 2'd0;
        end else begin
            if (accept && squashing) begin
                squash_cnt <= squash_cnt - 2'd1;
            end else if (live && taken) begin
                squash_cnt <= SQUASH_RELOAD;
            end

            if (live) begin
                out_valid     <= 1'b1;
                out_result    <= alu_result;
                out_rd        <= rd;
                out_we        <= (func_class == CLS_FLAG_SET) || (func_class == CLS_WRITE);
                out_illegal   <= func_class == CLS_ILLEGAL;
                branch_taken  <= taken;
                branch_target <= taken ? brfl_target : '0;
                if (func_class == CLS_FLAG_SET) begin
                    flags <= alu_flags;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_flags_stage.sv
// Directed bench for ex_flags_stage: transaction-level model checked every
// cycle, plus literal expectations at the key points of the sequence.
module tb_ex_flags_stage;

    localparam int DW = 32;
    localparam int SQ = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] alu_result = '0;
    logic [2:0]    alu_flags = '0;
    logic [5:0]    func = '0;
    logic [4:0]    rd = '0;
    logic [2:0]    brfl_mask = '0;
    logic [DW-1:0] brfl_target = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_result;
    logic [4:0]    out_rd;
    logic          out_we;
    logic          out_illegal;
    logic          branch_taken;
    logic [DW-1:0] branch_target;
    logic [2:0]    flags;

    int checks = 0;
    int errors = 0;

    ex_flags_stage #(.DATA_WIDTH(DW), .SQUASH_COUNT(SQ)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_flags(alu_flags), .func(func), .rd(rd),
        .brfl_mask(brfl_mask), .brfl_target(brfl_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
        .out_illegal(out_illegal), .branch_taken(branch_taken),
        .branch_target(branch_target), .flags(flags)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The stage is an instruction register plus a flag register plus a count
    // of upcoming inputs that belong to the wrong path.
    bit          m_valid = 0;
    logic [DW-1:0] m_result = '0;
    logic [4:0]  m_rd = '0;
    bit          m_we = 0;
    bit          m_ill = 0;
    bit          m_taken = 0;
    logic [DW-1:0] m_target = '0;
    logic [2:0]  m_flags = '0;
    int          m_discard = 0;

    function automatic void classify(input logic [5:0] f, output bit writes,
                                     output bit sets_flags, output bit illegal);
        writes = 0; sets_flags = 0; illegal = 0;
        case (f)
            6'b100000, 6'b100010, 6'b011000, 6'b011010: begin writes = 1; sets_flags = 1; end
            6'b100100, 6'b100101, 6'b100111:            writes = 1;
            6'b111111:                                  ;
            default:                                    illegal = 1;
        endcase
    endfunction

    always @(posedge clock) begin
        bit wr, fs, il, tk, acc;
        if (reset) begin
            m_valid = 0; m_result = '0; m_rd = '0; m_we = 0; m_ill = 0;
            m_taken = 0; m_target = '0; m_flags = '0; m_discard = 0;
        end else begin
            acc = in_valid && (!m_valid || out_ready);
            if (acc && m_discard > 0) begin
                m_discard = m_discard - 1;
                if (out_ready) m_valid = 0;
            end else if (acc) begin
                classify(func, wr, fs, il);
                tk = (func == 6'b111111) && ((m_flags & brfl_mask) != 3'b000);
                m_valid = 1; m_result = alu_result; m_rd = rd; m_we = wr; m_ill = il;
                m_taken = tk; m_target = tk ? brfl_target : '0;
                if (tk) m_discard = SQ;
                if (fs) m_flags = alu_flags;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clock) begin
        check("in_ready", in_ready, (!m_valid || out_ready));
        check("out_valid", out_valid, m_valid);
        check("flags", flags, m_flags);
        if (m_valid) begin
            check("out_result", out_result, m_result);
            check("out_rd", out_rd, m_rd);
            check("out_we", out_we, m_we);
            check("out_illegal", out_illegal, m_ill);
            check("branch_taken", branch_taken, m_taken);
            check("branch_target", branch_target, m_target);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input logic v, input logic [5:0] f, input logic [2:0] fl,
                       input logic [4:0] r, input logic [DW-1:0] res,
                       input logic [2:0] mask, input logic [DW-1:0] tgt);
        in_valid = v; func = f; alu_flags = fl; rd = r; alu_result = res;
        brfl_mask = mask; brfl_target = tgt;
        @(posedge clock);
        #1;
    endtask

    localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, MUL = 6'b011000,
                           DIV = 6'b011010, AND = 6'b100100, OR = 6'b100101,
                           BRFL = 6'b111111, BAD = 6'b000001;

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst out_valid", out_valid, 1'b0);
        check("rst flags", flags, 3'b000);
        check("rst out_result", out_result, 0);
        check("rst branch_target", branch_target, 0);
        reset = 1'b0;
        check("rst in_ready", in_ready, 1'b1);

        cyc(1, SUB, 3'b010, 5'd4, 0, 3'b000, 0);
        check("sub valid", out_valid, 1'b1);
        check("sub we", out_we, 1'b1);
        check("sub rd", out_rd, 5'd4);
        check("sub flags", flags, 3'b010);

        cyc(1, BRFL, 3'b111, 5'd1, 7, 3'b010, 32'h40);
        check("brfl taken", branch_taken, 1'b1);
        check("brfl target", branch_target, 32'h40);
        check("brfl we", out_we, 1'b0);
        check("brfl flags kept", flags, 3'b010);

        cyc(1, ADD, 3'b100, 5'd5, 11, 3'b000, 0);
        check("squash1 no out", out_valid, 1'b0);
        cyc(1, ADD, 3'b100, 5'd6, 22, 3'b000, 0);
        check("squash2 no out", out_valid, 1'b0);
        check("squash flags", flags, 3'b010);
        cyc(1, ADD, 3'b100, 5'd7, 33, 3'b000, 0);
        check("post-squash rd", out_rd, 5'd7);
        check("post-squash flags", flags, 3'b100);

        cyc(1, BRFL, 3'b000, 5'd2, 0, 3'b011, 32'h80);
        check("brfl not taken", branch_taken, 1'b0);
        check("brfl nt target", branch_target, 0);
        cyc(1, ADD, 3'b001, 5'd8, 44, 3'b000, 0);
        check("no squash rd", out_rd, 5'd8);
        cyc(1, AND, 3'b110, 5'd9, 55, 3'b000, 0);
        check("and flags", flags, 3'b001);
        check("and we", out_we, 1'b1);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1, OR, 3'b111, 5'd10, 66, 3'b000, 0);
            check("stall in_ready", in_ready, 1'b0);
            check("stall rd held", out_rd, 5'd9);
            check("stall result held", out_result, 55);
        end
        out_ready = 1'b1;
        cyc(1, OR, 3'b111, 5'd10, 66, 3'b000, 0);
        check("retire+load valid", out_valid, 1'b1);
        check("retire+load rd", out_rd, 5'd10);
        check("or flags", flags, 3'b001);

        cyc(1, BAD, 3'b111, 5'd11, 77, 3'b000, 0);
        check("illegal flag", out_illegal, 1'b1);
        check("illegal we", out_we, 1'b0);
        check("illegal flags", flags, 3'b001);

        cyc(1, MUL, 3'b010, 5'd3, 88, 3'b000, 0);
        cyc(1, BRFL, 3'b000, 5'd0, 0, 3'b010, 32'h100);
        check("brfl2 taken", branch_taken, 1'b1);
        cyc(1, SUB, 3'b111, 5'd12, 99, 3'b000, 0);
        check("squash one", out_valid, 1'b0);

        reset = 1'b1;
        cyc(0, ADD, 3'b000, 5'd0, 0, 3'b000, 0);
        check("mid-squash rst valid", out_valid, 1'b0);
        check("mid-squash rst flags", flags, 3'b000);
        check("mid-squash rst rd", out_rd, 5'd0);
        reset = 1'b0;
        cyc(1, DIV, 3'b100, 5'd13, 123, 3'b000, 0);
        check("after rst not squashed", out_rd, 5'd13);
        check("div flags", flags, 3'b100);
        cyc(1, BRFL, 3'b000, 5'd0, 0, 3'b100, 32'h200);
        check("b2b brfl taken", branch_taken, 1'b1);
        check("b2b brfl target", branch_target, 32'h200);

        cyc(0, ADD, 3'b000, 5'd0, 0, 3'b000, 0);
        check("idle retire", out_valid, 1'b0);
        cyc(1, ADD, 3'b001, 5'd14, 1, 3'b000, 0);
        cyc(1, ADD, 3'b001, 5'd15, 2, 3'b000, 0);
        check("squash after idle", flags, 3'b100);
        cyc(1, ADD, 3'b001, 5'd16, 3, 3'b000, 0);
        check("final rd", out_rd, 5'd16);
        check("final flags", flags, 3'b001);
        cyc(0, ADD, 3'b000, 5'd0, 0, 3'b000, 0);
        cyc(0, ADD, 3'b000, 5'd0, 0, 3'b000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
